id_issue_queue: RTL and testbench
=================================

Name: id_issue_queue

Overview:
- Decode-side transmitter for the ID→issue handshake: buffers decoded scoreboard entries from the decoder.
- Presents up to NrLanes in-order entries per cycle to the issue stage on decoded_instr_valid/ack.
- Retires entries as the issue stage acknowledges them.
- Decouples decoder timing from issue back-pressure; supports dual-issue (SUPERSCALAR=1) and single-issue builds.

Parameters:
- CVA6Cfg, config_pkg::cva6_cfg_empty, core configuration.
- scoreboard_entry_t, logic, decoded instruction entry type.
- NrLanes, SUPERSCALAR+1, lanes per cycle (1 or 2).
- DEPTH, 4, queue entries; power of two, DEPTH >= 2*NrLanes.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- flush_i  in  1  discard all buffered entries (flush_unissued)
- in_valid_i  in  NrLanes  decoder lanes valid; contiguous from lane 0
- in_entry_i  in  NrLanes x scoreboard_entry_t  decoded entries
- in_orig_instr_i  in  NrLanes x 32  raw instruction words
- in_is_ctrl_flow_i  in  NrLanes  control-flow flag per lane
- in_ready_o  out  1  queue accepts a full NrLanes group this cycle
- decoded_instr_o  out  NrLanes x scoreboard_entry_t  head entries, lane 0 = oldest
- orig_instr_o  out  NrLanes x 32  raw words of head entries
- is_ctrl_flow_o  out  NrLanes  flags of head entries
- decoded_instr_valid_o  out  NrLanes  lane i valid iff count > i
- decoded_instr_ack_i  in  NrLanes  issue-stage acknowledge; contiguous from lane 0
- occupancy_o  out  $clog2(DEPTH+1)  current entry count

Behaviour:
- Reset (rst_i high, async): count=0, rd_ptr=wr_ptr=0. Outputs: decoded_instr_valid_o=0, in_ready_o=1, occupancy_o=0. Data outputs are '0 while their lane is invalid.
- in_ready_o = (DEPTH - count) >= NrLanes, from registered count only; no combinational path from ack.
- Push: when in_ready_o, write each lane i with in_valid_i[i] at wr_ptr+i (mod DEPTH), in lane order. wr_ptr += popcount(in_valid_i).
- Push when in_ready_o=0 is dropped; the decoder holds its data.
- Pop: n = popcount(decoded_instr_ack_i & decoded_instr_valid_o). rd_ptr += n; entries leave in order.
- Output lane i = storage[rd_ptr+i] (mod DEPTH), combinational from the registers.
- Latency: an entry pushed in cycle N is visible at the output in cycle N+1. No fall-through.
- Simultaneous push and pop: count_next = count + pushed - popped. Legal at count=0 (no output that cycle) and when full (pops free space from the next cycle).
- Pointers are $clog2(DEPTH) bits and wrap naturally; lane+1 indexing wraps past DEPTH-1 to 0.
- flush_i: count, rd_ptr and wr_ptr go to 0 next cycle.
  - Pushes and acks in the same cycle are ignored; flush dominates.
  - Valid outputs stay asserted during the flush cycle and go low next cycle.
- Reset mid-operation clears state immediately (async); storage contents are don't-care.
- Protocol assertions (sim only):
  - ack[i] without valid_o[i].
  - Non-contiguous in_valid_i or ack (bit 1 set, bit 0 clear).
  - count > DEPTH.

Decomposition:
- ariane_pkg: SUPERSCALAR and the derived NrLanes constant.
- scoreboard_entry_t is passed as a type parameter, as across the core.
- Storage: one flat register array of {entry, orig_instr, is_ctrl_flow}.
- Pointer/count update is small enough to stay inline; no sub-module.

Test Plan:
- Reset then idle, DEPTH=4, NrLanes=2 → valid_o=00, in_ready_o=1, occupancy_o=0.
- Push {A,B} at cycle 1, ack=00 → cycle 2: valid_o=11, lane0=A, lane1=B, occupancy=2. Push {C,D} → occupancy=4, in_ready_o=0.
- Full queue (A–D), ack=01 with push {E,F} → E,F dropped, occupancy=3, lane0=B, lane1=C. Next cycle in_ready_o still 0 because free=1 < 2.
- Wrap: 6 push/ack cycles of {X_k,Y_k} with ack=11 every cycle → order preserved across the pointer wrap, occupancy stays 2.
- Flush with occupancy=3 plus push and ack=11 in the same cycle → next cycle occupancy=0, valid_o=00, in_ready_o=1. A subsequent push appears as lane0.
- Single-lane push (in_valid=01) of G, then ack=01 → G issued alone, occupancy back to 0. Async rst_i mid-stream clears valid_o within the same cycle.

Source files
------------

// File: rtl/id_issue_queue_pkg.sv
// Shared constants for the decode-to-issue queue: lane count and default depth.
package id_issue_queue_pkg;

  localparam bit          SUPERSCALAR = 1'b1;
  localparam int unsigned NR_LANES    = SUPERSCALAR ? 2 : 1;
  localparam int unsigned QUEUE_DEPTH = 4;
  localparam int unsigned INSTR_W     = 32;

endpackage

// File: rtl/id_issue_queue.sv
// In-order buffer between decode and issue: accepts up to NrLanes entries per
// cycle and presents up to NrLanes head entries, retiring them on acknowledge.
module id_issue_queue
  import id_issue_queue_pkg::*;
#(
  parameter type         scoreboard_entry_t = logic,
  parameter int unsigned NrLanes            = NR_LANES,
  parameter int unsigned DEPTH              = QUEUE_DEPTH
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  flush_i,
  input  logic              [NrLanes-1:0]       in_valid_i,
  input  scoreboard_entry_t [NrLanes-1:0]       in_entry_i,
  input  logic              [NrLanes-1:0][31:0] in_orig_instr_i,
  input  logic              [NrLanes-1:0]       in_is_ctrl_flow_i,
  output logic                                  in_ready_o,
  output scoreboard_entry_t [NrLanes-1:0]       decoded_instr_o,
  output logic              [NrLanes-1:0][31:0] orig_instr_o,
  output logic              [NrLanes-1:0]       is_ctrl_flow_o,
  output logic              [NrLanes-1:0]       decoded_instr_valid_o,
  input  logic              [NrLanes-1:0]       decoded_instr_ack_i,
  output logic              [$clog2(DEPTH+1)-1:0] occupancy_o
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = $clog2(DEPTH+1);
  localparam int unsigned EntryW = $bits(scoreboard_entry_t);
  localparam int unsigned SlotW  = EntryW + INSTR_W + 1;

  // Slot layout: {entry, orig_instr, is_ctrl_flow}
  logic [SlotW-1:0] mem_q [DEPTH];
  logic [SlotW-1:0] rd_slot [NrLanes];

  logic [CntW-1:0]    count_q;
  logic [PtrW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]    n_push, n_pop;
  logic [NrLanes-1:0] lane_valid;
  logic               push_en;

  assign in_ready_o  = (CntW'(DEPTH) - count_q) >= CntW'(NrLanes);
  assign push_en     = in_ready_o & ~flush_i;
  assign occupancy_o = count_q;

  always_comb begin
    for (int i = 0; i < NrLanes; i++) begin
      lane_valid[i] = count_q > CntW'(i);
    end
  end

  assign decoded_instr_valid_o = lane_valid;

  always_comb begin
    n_push = '0;
    n_pop  = '0;
    for (int i = 0; i < NrLanes; i++) begin
      n_push = n_push + CntW'(in_valid_i[i] & push_en);
      n_pop  = n_pop + CntW'(decoded_instr_ack_i[i] & lane_valid[i]);
    end
  end

  // Head lanes read straight from storage; invalid lanes are forced to zero.
  always_comb begin
    for (int i = 0; i < NrLanes; i++) begin
      rd_slot[i]         = lane_valid[i] ? mem_q[rd_ptr_q + PtrW'(i)] : '0;
      decoded_instr_o[i] = rd_slot[i][SlotW-1 -: EntryW];
      orig_instr_o[i]    = rd_slot[i][INSTR_W:1];
      is_ctrl_flow_o[i]  = rd_slot[i][0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) begin
      for (int i = 0; i < NrLanes; i++) begin
        if (in_valid_i[i]) begin
          mem_q[wr_ptr_q + PtrW'(i)] <= {in_entry_i[i], in_orig_instr_i[i], in_is_ctrl_flow_i[i]};
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else if (flush_i) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q  <= count_q + n_push - n_pop;
      wr_ptr_q <= wr_ptr_q + PtrW'(n_push);
      rd_ptr_q <= rd_ptr_q + PtrW'(n_pop);
    end
  end

`ifndef SYNTHESIS
  ack_without_valid: assert property (@(posedge clk_i) disable iff (rst_i)
    (decoded_instr_ack_i & ~lane_valid) == '0)
    else $error("ack asserted on a lane without valid");

  // A mask of the form 0..01..1 has no bit in common with itself plus one.
  in_valid_contig: assert property (@(posedge clk_i) disable iff (rst_i)
    (in_valid_i & (in_valid_i + NrLanes'(1))) == '0)
    else $error("in_valid_i not contiguous from lane 0");

  ack_contig: assert property (@(posedge clk_i) disable iff (rst_i)
    (decoded_instr_ack_i & (decoded_instr_ack_i + NrLanes'(1))) == '0)
    else $error("decoded_instr_ack_i not contiguous from lane 0");

  count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    count_q <= CntW'(DEPTH))
    else $error("count exceeds DEPTH");
`endif

endmodule

// File: tb/tb_id_issue_queue.sv
// Randomized and directed bench for id_issue_queue, checked against a queue-based
// model of the buffered entries.
module tb_id_issue_queue;

  typedef logic [15:0] sbe_t;
  typedef struct packed {
    sbe_t        e;
    logic [31:0] w;
    logic        cf;
  } item_t;

  localparam int L = 2;
  localparam int D = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic [1:0]       in_valid = '0;
  sbe_t [1:0]       in_entry = '0;
  logic [1:0][31:0] in_instr = '0;
  logic [1:0]       in_cf = '0;
  logic             in_ready;
  sbe_t [1:0]       out_entry;
  logic [1:0][31:0] out_instr;
  logic [1:0]       out_cf;
  logic [1:0]       out_valid;
  logic [1:0]       ack = '0;
  logic [2:0]       occupancy;

  id_issue_queue #(
    .scoreboard_entry_t(sbe_t),
    .NrLanes           (L),
    .DEPTH             (D)
  ) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .flush_i              (flush),
    .in_valid_i           (in_valid),
    .in_entry_i           (in_entry),
    .in_orig_instr_i      (in_instr),
    .in_is_ctrl_flow_i    (in_cf),
    .in_ready_o           (in_ready),
    .decoded_instr_o      (out_entry),
    .orig_instr_o         (out_instr),
    .is_ctrl_flow_o       (out_cf),
    .decoded_instr_valid_o(out_valid),
    .decoded_instr_ack_i  (ack),
    .occupancy_o          (occupancy)
  );

  always #5 clk = ~clk;

  item_t sb[$];
  int    n_cmp = 0;
  int    n_err = 0;
  bit    exp_ready = 1'b1;
  int    m_sz;
  int    m_n;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares presented head lanes with the model, then retires acked entries.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_occupancy", 64'(occupancy), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      exp_ready = 1'b1;
    end else begin
      m_sz = sb.size();
      check("occupancy", 64'(occupancy), 64'(m_sz));
      check("in_ready", 64'(in_ready), 64'((D - m_sz) >= L));
      for (int i = 0; i < L; i++) begin
        check($sformatf("valid%0d", i), 64'(out_valid[i]), 64'(m_sz > i));
        if (m_sz > i) begin
          check($sformatf("entry%0d", i), 64'(out_entry[i]), 64'(sb[i].e));
          check($sformatf("instr%0d", i), 64'(out_instr[i]), 64'(sb[i].w));
          check($sformatf("cf%0d", i), 64'(out_cf[i]), 64'(sb[i].cf));
        end else begin
          check($sformatf("idle_data%0d", i),
                {15'd0, out_cf[i], out_instr[i], out_entry[i]}, 64'd0);
        end
      end
      m_n = 0;
      for (int i = 0; i < L; i++) if (ack[i] && m_sz > i) m_n++;
      repeat (m_n) void'(sb.pop_front());
      exp_ready = (D - m_sz) >= L;
    end
  end

  // Model capture: pushes are taken only when the queue had room at cycle start.
  always @(posedge clk) begin
    if (!rst) begin
      if (flush) begin
        sb.delete();
      end else if (exp_ready) begin
        for (int i = 0; i < L; i++) begin
          if (in_valid[i]) sb.push_back('{e: in_entry[i], w: in_instr[i], cf: in_cf[i]});
        end
      end
    end
  end

  task automatic step(input logic [1:0] v, input logic [1:0] a, input logic f);
    @(posedge clk);
    #1;
    in_valid = v;
    ack      = a;
    flush    = f;
    for (int i = 0; i < L; i++) begin
      in_entry[i] = sbe_t'($urandom);
      in_instr[i] = $urandom;
      in_cf[i]    = 1'($urandom);
    end
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    rst      = 1'b1;
    sb.delete();
    in_valid = '0;
    ack      = '0;
    flush    = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_occupancy", 64'(occupancy), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] v, a;
    int         k;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    step(2'b00, 2'b00, 1'b0);
    step(2'b11, 2'b00, 1'b0);
    step(2'b11, 2'b00, 1'b0);
    step(2'b00, 2'b00, 1'b0);
    step(2'b11, 2'b01, 1'b0);  // full: push dropped, one retired
    step(2'b00, 2'b00, 1'b0);
    step(2'b00, 2'b11, 1'b0);
    step(2'b00, 2'b01, 1'b0);
    step(2'b11, 2'b00, 1'b0);
    repeat (6) step(2'b11, 2'b11, 1'b0);  // steady state across pointer wrap
    step(2'b00, 2'b11, 1'b0);
    step(2'b11, 2'b00, 1'b0);
    step(2'b01, 2'b00, 1'b0);
    step(2'b11, 2'b11, 1'b1);  // flush beats push and ack
    step(2'b01, 2'b00, 1'b0);
    step(2'b00, 2'b01, 1'b0);
    step(2'b01, 2'b00, 1'b0);
    step(2'b00, 2'b01, 1'b0);
    step(2'b00, 2'b00, 1'b0);
    step(2'b11, 2'b00, 1'b0);
    step(2'b11, 2'b01, 1'b0);
    async_reset();

    for (int c = 0; c < 500; c++) begin
      k = $urandom_range(0, 2);
      v = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : 2'b11;
      @(posedge clk);
      #1;
      k = $urandom_range(0, (sb.size() >= 2) ? 2 : sb.size());
      a = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : 2'b11;
      in_valid = v;
      ack      = a;
      flush    = ($urandom_range(0, 24) == 0);
      for (int i = 0; i < L; i++) begin
        in_entry[i] = sbe_t'($urandom);
        in_instr[i] = $urandom;
        in_cf[i]    = 1'($urandom);
      end
      if (c == 250) async_reset();
    end

    step(2'b00, 2'b00, 1'b0);
    repeat (3) step(2'b00, 2'b00, 1'b0);
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
